// File: rtl/read_reg_pkg.sv
// Shared definitions for the 16x4 register file read/write sides.
package read_reg_pkg;

  localparam int RR_AW = 4;
  localparam int RR_DW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } rr_state_e;

endpackage

// File: rtl/read_reg_burst_if.sv
// Output beat stream of the register-file burst reader (valid/ready).
interface read_reg_burst_if
  import read_reg_pkg::*;
#(
  parameter int AW = RR_AW,
  parameter int DW = RR_DW
);

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  modport master (output out_valid, output out_addr, output out_data, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/reg_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; head is visible whenever count != 0.
module reg_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    w_pop_ok  = i_pop && (r_count != 2'd0);
    w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= {W{1'b0}};
      r_mem[1] <= {W{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/read_reg_burst.sv
// Burst reader for the register file: reads len consecutive registers (wrapping)
// and streams {addr, data} beats through a 2-entry skid FIFO.
module read_reg_burst
  import read_reg_pkg::*;
#(
  parameter int AW = RR_AW,
  parameter int DW = RR_DW,
  parameter int LW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [AW-1:0]          i_base_addr,
  input  logic [LW-1:0]          i_len,
  output logic [AW-1:0]          o_ra,
  input  logic [DW-1:0]          i_busr,
  read_reg_burst_if.master       o_out,
  output logic                   o_busy,
  output logic                   o_done
);

  rr_state_e      r_state;
  rr_state_e      w_state_nxt;
  logic [AW-1:0]  r_addr;
  logic [LW-1:0]  r_rem;
  logic           r_done;
  logic           w_done_nxt;
  logic           w_push;
  logic           w_pop;
  logic           w_launch;
  logic [1:0]     w_count;
  logic [AW+DW-1:0] w_head;

  assign w_pop = o_out.out_valid && o_out.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, FIFO push and completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_done_nxt  = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_len != {LW{1'b0}})) begin
          w_launch    = 1'b1;
          w_state_nxt = S_READ;
        end else if (i_start) begin
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_count != 2'd2) begin
          w_push = 1'b1;
          if (r_rem == LW'(1)) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_READ;
          end
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_DRAIN: begin
        // The final handshake empties the FIFO; done follows it by one cycle.
        if (w_count == 2'd0) begin
          w_state_nxt = S_IDLE;
        end else if ((w_count == 2'd1) && w_pop) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address and remaining-count counters plus the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= {AW{1'b0}};
      r_rem  <= {LW{1'b0}};
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_launch) begin
        r_addr <= i_base_addr;
        r_rem  <= i_len;
      end else if (w_push) begin
        r_addr <= r_addr + AW'(1);
        r_rem  <= r_rem - LW'(1);
      end else begin
        r_addr <= r_addr;
        r_rem  <= r_rem;
      end
    end
  end

  reg_skid_fifo #(
    .W (AW + DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({r_addr, i_busr}),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign o_ra           = r_addr;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_out.out_valid = (w_count != 2'd0);
  assign o_out.out_addr  = w_head[AW+DW-1:DW];
  assign o_out.out_data  = w_head[DW-1:0];

endmodule

// File: tb/tb_read_reg_burst.sv
// Directed bench for read_reg_burst: a burst-level reference model checked every
// cycle, plus hand-computed beat/latency expectations.
module tb_read_reg_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = 4'd0;
  logic [4:0] len = 5'd0;
  logic [3:0] ra;
  logic [3:0] busr;
  logic       busy;
  logic       done;
  logic [3:0] regs [16];

  int vectors = 0;
  int miscompares = 0;
  bit m_en = 1'b0;
  bit m_active = 1'b0;
  bit m_done_exp = 1'b0;
  logic [7:0] m_q [$];
  int hs_cnt = 0;
  int done_cnt = 0;

  read_reg_burst_if #(.AW(4), .DW(4)) u_if ();

  read_reg_burst dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_len       (len),
    .o_ra        (ra),
    .i_busr      (busr),
    .o_out       (u_if),
    .o_busy      (busy),
    .o_done      (done)
  );

  assign busr = regs[ra];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a burst is the list of (base+k) mod 16 for k<len; done follows
  // the handshake of its last beat, or the start edge of a zero-length command.
  always @(negedge clk) begin
    if (m_en) begin
      chk("busy", busy, m_active);
      chk("done", done, m_done_exp);
      if (u_if.out_valid) begin
        if (m_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("beat", {u_if.out_addr, u_if.out_data}, m_q[0]);
        end
      end
      m_done_exp = 1'b0;
      if (rst) begin
        m_active = 1'b0;
        m_q.delete();
      end else begin
        if (u_if.out_valid && u_if.out_ready && m_q.size() != 0) begin
          void'(m_q.pop_front());
          hs_cnt++;
          if (m_q.size() == 0) begin
            m_done_exp = 1'b1;
            m_active = 1'b0;
          end
        end
        if (!m_active && start && !m_done_exp) begin
          if (len == 5'd0) begin
            m_done_exp = 1'b1;
          end else begin
            m_active = 1'b1;
            for (int k = 0; k < int'(len); k++) begin
              logic [3:0] a;
              a = base_addr + 4'(k);
              m_q.push_back({a, regs[a]});
            end
          end
        end
      end
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic launch(input logic [3:0] b, input logic [4:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      if (rnd) u_if.out_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    chk("done_timeout", (n < 300), 1);
  endtask

  initial begin
    logic [3:0] e_a [4];
    logic [3:0] e_d [4];
    int hs0;
    int dn0;
    for (int k = 0; k < 16; k++) regs[k] = 4'(15 - k);
    u_if.out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_ra", ra, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    m_en = 1'b1;
    cyc();

    // Basic burst with hand-computed beats.
    e_a = '{4'd3, 4'd4, 4'd5, 4'd6};
    e_d = '{4'hC, 4'hB, 4'hA, 4'h9};
    launch(4'd3, 5'd4);
    chk("t1_ra_c1", ra, 3);
    chk("t1_busy_c1", busy, 1);
    chk("t1_valid_c1", u_if.out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t1_valid", u_if.out_valid, 1);
      chk("t1_addr", u_if.out_addr, e_a[k]);
      chk("t1_data", u_if.out_data, e_d[k]);
      chk("t1_busy", busy, 1);
    end
    cyc();
    chk("t1_done_c6", done, 1);
    chk("t1_busy_c6", busy, 0);
    chk("t1_valid_c6", u_if.out_valid, 0);
    cyc();
    chk("t1_done_c7", done, 0);

    // Wrap 15 -> 0.
    e_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    e_d = '{4'h1, 4'h0, 4'hF, 4'hE};
    launch(4'd14, 5'd4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t2_addr", u_if.out_addr, e_a[k]);
      chk("t2_data", u_if.out_data, e_d[k]);
    end
    cyc();
    chk("t2_done", done, 1);
    cyc();

    // Backpressure: ready low in cycles 2..6.
    launch(4'd0, 5'd3);
    chk("t3_ra_c1", ra, 0);
    u_if.out_ready = 1'b0;
    cyc();
    chk("t3_ra_c2", ra, 1);
    for (int c = 3; c <= 6; c++) begin
      cyc();
      chk("t3_ra_hold", ra, 2);
      chk("t3_valid_hold", u_if.out_valid, 1);
      chk("t3_addr_hold", u_if.out_addr, 0);
      chk("t3_data_hold", u_if.out_data, 4'hF);
    end
    cyc();
    u_if.out_ready = 1'b1;
    wait_done(1'b0);
    cyc();

    // Zero-length command.
    launch(4'd7, 5'd0);
    chk("t4_done_c1", done, 1);
    chk("t4_busy_c1", busy, 0);
    chk("t4_valid_c1", u_if.out_valid, 0);
    cyc();
    chk("t4_done_c2", done, 0);
    chk("t4_busy_c2", busy, 0);

    // Start while busy is ignored.
    hs0 = hs_cnt;
    launch(4'd2, 5'd5);
    cyc();
    start = 1'b1;
    base_addr = 4'd9;
    len = 5'd3;
    cyc();
    start = 1'b0;
    wait_done(1'b0);
    repeat (4) cyc();
    chk("t5_beats", hs_cnt - hs0, 5);

    // Reset in cycle 3 of a len=8 burst.
    launch(4'd5, 5'd8);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_valid", u_if.out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ra", ra, 0);
    cyc();
    hs0 = hs_cnt;
    launch(4'd0, 5'd2);
    wait_done(1'b0);
    cyc();
    chk("t6_after_beats", hs_cnt - hs0, 2);

    // Full-depth burst with random backpressure.
    hs0 = hs_cnt;
    dn0 = done_cnt;
    launch(4'd0, 5'd16);
    wait_done(1'b1);
    u_if.out_ready = 1'b1;
    repeat (5) cyc();
    chk("t7_beats", hs_cnt - hs0, 16);
    chk("t7_done_pulses", done_cnt - dn0, 1);
    chk("model_empty", m_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
